// File: rtl/alu_console.sv
// alu_console: button-driven console that loads A/B/FUNC from switches and executes A <= ALU(A,B,FUNC).
// Latency: loads/executes take effect at the press edge; y/of/zf follow A/B/FUNC one cycle later.
// Backpressure: none; one action per rising edge of en, extra edges while en is held are ignored.
module alu_console #(
   parameter int WIDTH = 6,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             of,
   output logic             zf,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_FUNC = 2'b10;
   localparam logic [1:0] SEL_EXEC = 2'b11;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       func;
   logic             en_q;
   logic             press;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             shift_big;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   // One-cycle pulse on the rising edge of the raw button level.
   assign press = en & ~en_q;

   assign sum       = a + b;
   assign diff      = a - b;
   // Shift amounts are B unsigned; anything at or beyond WIDTH saturates.
   assign shift_big = 32'(b) >= 32'(WIDTH);

   // Combinational ALU; overflow is only meaningful for add and sub.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (func)
         4'd0: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'd1: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         4'd2:    alu_res = a & b;
         4'd3:    alu_res = a | b;
         4'd4:    alu_res = a ^ b;
         4'd5:    alu_res = ~a;
         4'd6:    alu_res = shift_big ? '0 : (a << b);
         4'd7:    alu_res = shift_big ? '0 : (a >> b);
         4'd8:    alu_res = shift_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
         4'd9:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd10:   alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: alu_res = '0;
      endcase
   end

   // Edge detector, registered ALU outputs and the press-driven operand/status updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // en_q held high so a button still down at release does not fire.
         en_q       <= 1'b1;
         a          <= '0;
         b          <= '0;
         func       <= 4'd0;
         y          <= '0;
         of         <= 1'b0;
         zf         <= 1'b1;
         ovf_sticky <= 1'b0;
         cnt        <= '0;
      end else begin
         en_q <= en;
         y    <= alu_res;
         of   <= alu_ovf;
         zf   <= (alu_res == '0);
         if (press) begin
            case (sel)
               SEL_A: begin
                  a          <= x;
                  cnt        <= '0;
                  ovf_sticky <= 1'b0;
               end
               SEL_B:    b    <= x;
               SEL_FUNC: func <= x[3:0];
               SEL_EXEC: begin
                  a   <= alu_res;
                  cnt <= cnt + CNT_W'(1);
                  if (alu_ovf) ovf_sticky <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_console.sv
// Bench for alu_console: hand-computed press table, held-button and reset sequences,
// then random presses checked against an arithmetic reference model.
module tb_alu_console;

   localparam int W = 6;
   localparam int C = 4;

   logic         clk;
   logic         rst;
   logic         en;
   logic [1:0]   sel;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         of;
   logic         zf;
   logic         ovf_sticky;
   logic [C-1:0] cnt;

   int tests;
   int fails;

   // reference state
   int ma, mb, mf, mcnt;
   bit msticky;

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         of;
      logic         zf;
      logic         st;
      logic [C-1:0] cnt;
   } vec_t;

   vec_t vecs[$];

   alu_console #(.WIDTH(W), .CNT_W(C)) dut (
      .clk(clk), .rst(rst), .en(en), .sel(sel), .x(x),
      .y(y), .of(of), .zf(zf), .ovf_sticky(ovf_sticky), .cnt(cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference ALU from the opcode definitions using plain integer arithmetic.
   function automatic void ref_alu(input int a, input int b, input int f, output int r, output bit ov);
      int m, sa, sb, p;
      longint t;
      m  = 1 << W;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      p  = (b < W) ? (1 << b) : 1;
      ov = 1'b0;
      t  = 0;
      case (f)
         0: begin t = sa + sb; ov = (t > m / 2 - 1) || (t < -(m / 2)); end
         1: begin t = sa - sb; ov = (t > m / 2 - 1) || (t < -(m / 2)); end
         2: t = a & b;
         3: t = a | b;
         4: t = a ^ b;
         5: t = (m - 1) - a;
         6: t = (b >= W) ? 0 : longint'(a) * p;
         7: t = (b >= W) ? 0 : a / p;
         8: begin
            if (b >= W) t = (sa < 0) ? -1 : 0;
            else if (sa >= 0) t = sa / p;
            else t = -((-sa + p - 1) / p);
         end
         9:  t = (sa < sb) ? 1 : 0;
         10: t = (a < b) ? 1 : 0;
         default: t = 0;
      endcase
      r = int'(((t % m) + m) % m);
   endfunction

   // Single press: en high across exactly one rising edge, then one more edge so y settles.
   // sel/x are scrambled after the press edge; the DUT must not sample them again.
   task automatic apply(input logic [1:0] s, input logic [W-1:0] v);
      int r;
      bit ov;
      en  = 1'b1;
      sel = s;
      x   = v;
      ref_alu(ma, mb, mf, r, ov);
      case (s)
         2'b00: begin ma = int'(v); mcnt = 0; msticky = 1'b0; end
         2'b01: mb = int'(v);
         2'b10: mf = int'(v[3:0]);
         default: begin ma = r; mcnt = (mcnt + 1) % (1 << C); msticky = msticky | ov; end
      endcase
      @(negedge clk);
      en  = 1'b0;
      sel = 2'($urandom);
      x   = W'($urandom);
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      int r;
      bit ov;
      ref_alu(ma, mb, mf, r, ov);
      chk({tag, "_y"},   int'(y), r);
      chk({tag, "_of"},  int'(of), int'(ov));
      chk({tag, "_zf"},  int'(zf), int'(r == 0));
      chk({tag, "_st"},  int'(ovf_sticky), int'(msticky));
      chk({tag, "_cnt"}, int'(cnt), mcnt);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_y"},   int'(y), 0);
      chk({tag, "_of"},  int'(of), 0);
      chk({tag, "_zf"},  int'(zf), 1);
      chk({tag, "_st"},  int'(ovf_sticky), 0);
      chk({tag, "_cnt"}, int'(cnt), 0);
   endtask

   task automatic add(input logic [1:0] s, input int v, input int ey, input bit eo, input bit ez,
                      input bit es, input int ec);
      vec_t e;
      e.sel = s; e.x = W'(v); e.y = W'(ey); e.of = eo; e.zf = ez; e.st = es; e.cnt = C'(ec);
      vecs.push_back(e);
   endtask

   initial begin
      tests = 0; fails = 0;
      ma = 0; mb = 0; mf = 0; mcnt = 0; msticky = 1'b0;

      //   sel    x   y  of zf st cnt
      add(2'd0,   5,  5, 0, 0, 0, 0);   // A=5
      add(2'd1,   3,  8, 0, 0, 0, 0);   // B=3
      add(2'd2,   0,  8, 0, 0, 0, 0);   // add -> 8
      add(2'd0,  31, 34, 1, 0, 0, 0);   // 31+3 overflows
      add(2'd1,   1, 32, 1, 0, 0, 0);   // 31+1 = 6'b100000
      add(2'd2,   1, 30, 0, 0, 0, 0);   // sub -> 30
      add(2'd3,   0, 29, 0, 0, 0, 1);   // A=30
      add(2'd0,   1,  0, 0, 1, 0, 0);   // A=1, 1-1=0
      add(2'd2,   0,  2, 0, 0, 0, 0);   // add
      add(2'd3,   0,  3, 0, 0, 0, 1);   // A=2
      add(2'd3,   0,  4, 0, 0, 0, 2);   // A=3
      add(2'd3,   0,  5, 0, 0, 0, 3);   // A=4
      add(2'd0,  32, 33, 0, 0, 0, 0);   // A=-32, -32+1
      add(2'd2,   1, 31, 1, 0, 0, 0);   // -32-1 overflows
      add(2'd3,   0, 30, 0, 0, 1, 1);   // A=31, sticky set
      add(2'd0,   0, 63, 0, 0, 0, 0);   // A=0 clears sticky/cnt; 0-1 = 63
      add(2'd1,   0,  0, 0, 1, 0, 0);   // B=0
      add(2'd0,   3,  3, 0, 0, 0, 0);
      add(2'd1,   2,  1, 0, 0, 0, 0);
      add(2'd2,   6, 12, 0, 0, 0, 0);   // 3<<2
      add(2'd1,   6,  0, 0, 1, 0, 0);   // shift by WIDTH -> 0
      add(2'd2,   8,  0, 0, 1, 0, 0);   // 3>>>6, positive
      add(2'd0,  40, 63, 0, 0, 0, 0);   // 101000>>>6 -> all ones
      add(2'd1,   2, 58, 0, 0, 0, 0);   // 101000>>>2 = 111010
      add(2'd2,   7, 10, 0, 0, 0, 0);   // 101000>>2 = 001010
      add(2'd2,   9,  1, 0, 0, 0, 0);   // -24 < 2 signed
      add(2'd2,  10,  0, 0, 1, 0, 0);   // 40 < 2 unsigned false
      add(2'd2,  12,  0, 0, 1, 0, 0);   // unused opcode
      add(2'd2,   5, 23, 0, 0, 0, 0);   // ~101000

      rst = 1'b1; en = 1'b0; sel = 2'b00; x = '0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         apply(vecs[i].sel, vecs[i].x);
         chk($sformatf("vec%0d_y", i),   int'(y), int'(vecs[i].y));
         chk($sformatf("vec%0d_of", i),  int'(of), int'(vecs[i].of));
         chk($sformatf("vec%0d_zf", i),  int'(zf), int'(vecs[i].zf));
         chk($sformatf("vec%0d_st", i),  int'(ovf_sticky), int'(vecs[i].st));
         chk($sformatf("vec%0d_cnt", i), int'(cnt), int'(vecs[i].cnt));
      end

      // Held button: only the first edge loads A; later sel/x changes are ignored.
      apply(2'd3, '0);
      en = 1'b1; sel = 2'd0; x = W'(1);
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         x   = W'(i + 1);
         sel = 2'(i % 4);
      end
      @(negedge clk);
      en = 1'b0;
      ma = 1; mcnt = 0; msticky = 1'b0;
      repeat (2) @(negedge clk);
      chk_model("held");

      // Random presses against the reference model.
      for (int i = 0; i < 300; i++) begin
         apply(2'($urandom_range(0, 3)), W'($urandom));
         chk_model($sformatf("rnd%0d", i));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // Reset mid-accumulate with the button held through release.
      apply(2'd0, W'(1));
      apply(2'd1, W'(1));
      apply(2'd2, W'(0));
      apply(2'd3, '0);
      en = 1'b1; sel = 2'd0; x = W'(17);
      #2 rst = 1'b1;
      #1 chk_reset("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ma = 0; mb = 0; mf = 0; mcnt = 0; msticky = 1'b0;
      repeat (3) @(negedge clk);
      chk_model("rst_held");
      en = 1'b0;
      @(negedge clk);
      apply(2'd0, W'(17));
      chk_model("rst_repress");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
